// File: rtl/store_rmw_if.sv
// store_rmw_if: store request handshake plus the word-wide data RAM port of store_rmw_ctrl
interface store_rmw_if #(parameter int AW = 32);
  logic          ReqValid;
  logic          ReqReady;
  logic [AW-1:0] ReqAddr;
  logic [1:0]    ReqType;
  logic [31:0]   ReqWData;
  logic          MemEn;
  logic          MemWE;
  logic [AW-1:0] MemAddr;
  logic [31:0]   MemWData;
  logic [31:0]   MemRData;
  logic          Done;
  logic          Err;
  logic          Busy;
  modport master (
    output ReqValid, ReqAddr, ReqType, ReqWData, MemRData,
    input  ReqReady, MemEn, MemWE, MemAddr, MemWData, Done, Err, Busy
  );
  modport slave (
    input  ReqValid, ReqAddr, ReqType, ReqWData, MemRData,
    output ReqReady, MemEn, MemWE, MemAddr, MemWData, Done, Err, Busy
  );
endinterface

// File: rtl/store_rmw_ctrl.sv
// store_rmw_ctrl: read-modify-write sequencer for byte/half stores into a word-wide RAM without byte enables
module store_rmw_ctrl #(
  parameter int MEM_LAT = 1,
  parameter int AW      = 32
) (
  input logic        clk,
  input logic        rst,
  store_rmw_if.slave bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;
  logic [2:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    type_q, type_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   merged;
  logic          accept;
  logic          mem_on;
  assign accept = bus.ReqValid && state_q == IDLE;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    type_d  = type_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    if (accept) begin
      addr_d  = bus.ReqAddr;
      type_d  = bus.ReqType;
      data_d  = bus.ReqWData;
      state_d = bus.ReqType[1] ? WRITE : (bus.ReqType[0] && bus.ReqAddr[0]) ? ERR : READ;
    end
    if (state_q == READ) begin
      state_d = WAIT;
      cnt_d   = 2'(MEM_LAT - 1);
    end
    if (state_q == WAIT) begin
      cnt_d   = cnt_q == 2'd0 ? 2'd0 : cnt_q - 2'd1;
      state_d = cnt_q == 2'd0 ? WRITE : WAIT;
      rdata_d = cnt_q == 2'd0 ? bus.MemRData : rdata_q;
    end
    if (state_q == WRITE || state_q == ERR) state_d = IDLE;
  end
  // Type 11 is treated as a full word store alongside 10.
  assign merged = type_q[1] ? data_q
                : type_q[0] ? (addr_q[1] ? {data_q[15:0], rdata_q[15:0]} : {rdata_q[31:16], data_q[15:0]})
                : addr_q[1:0] == 2'd0 ? {rdata_q[31:8], data_q[7:0]}
                : addr_q[1:0] == 2'd1 ? {rdata_q[31:16], data_q[7:0], rdata_q[7:0]}
                : addr_q[1:0] == 2'd2 ? {rdata_q[31:24], data_q[7:0], rdata_q[15:0]}
                : {data_q[7:0], rdata_q[23:0]};
  assign mem_on       = state_q == READ || state_q == WRITE;
  assign bus.ReqReady = state_q == IDLE;
  assign bus.Busy     = state_q != IDLE;
  assign bus.MemEn    = mem_on;
  assign bus.MemWE    = state_q == WRITE;
  assign bus.MemAddr  = mem_on ? {addr_q[AW-1:2], 2'b00} : '0;
  assign bus.MemWData = state_q == WRITE ? merged : 32'd0;
  assign bus.Done     = state_q == WRITE || state_q == ERR;
  assign bus.Err      = state_q == ERR;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      type_q  <= 2'd0;
      data_q  <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_store_rmw_ctrl.sv
// tb_store_rmw_ctrl: directed and random stores against two controllers (MEM_LAT 1 and 3) with RAM models
module tb_store_rmw_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [1:0]  req_type = 2'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        pl_en = 1'b0;
  logic [8:0]  pl_idx = 9'd0;
  logic [31:0] pl_val = 32'd0;
  logic [69:0] obs [2];
  logic [69:0] o;
  logic [31:0] ref_mem [2][512];
  int checks = 0;
  int errors = 0;
  localparam logic [69:0] IDLE_OUT = {6'b100000, 64'd0};
  always #5 clk = ~clk;
  store_rmw_if #(.AW(32)) bus [2] ();
  function automatic logic [31:0] seed(input int i);
    return i * 32'h9E37_79B9 ^ 32'hA5A5_0000;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = g ? 3 : 1;
    logic [31:0] ram [512];
    logic [31:0] pipe [LAT];
    assign bus[g].ReqValid = req_valid && sel == 1'(g);
    assign bus[g].ReqAddr  = req_addr;
    assign bus[g].ReqType  = req_type;
    assign bus[g].ReqWData = req_wdata;
    assign bus[g].MemRData = pipe[LAT-1];
    assign obs[g] = {bus[g].ReqReady, bus[g].Busy, bus[g].MemEn, bus[g].MemWE, bus[g].Done, bus[g].Err,
                     bus[g].MemAddr, bus[g].MemWData};
    store_rmw_ctrl #(.MEM_LAT(LAT), .AW(32)) dut (.clk(clk), .rst(rst), .bus(bus[g]));
    always @(posedge clk) begin
      if (init) for (int i = 0; i < 512; i++) ram[i] <= seed(i);
      else if (pl_en && sel == 1'(g)) ram[pl_idx] <= pl_val;
      else if (bus[g].MemEn && bus[g].MemWE) ram[bus[g].MemAddr[10:2]] <= bus[g].MemWData;
      pipe[0] <= (bus[g].MemEn && !bus[g].MemWE) ? ram[bus[g].MemAddr[10:2]] : 32'hDEAD_0000;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign o = obs[sel];
  function automatic logic [31:0] ram_at(input logic [31:0] a);
    return sel ? lane[1].ram[a[10:2]] : lane[0].ram[a[10:2]];
  endfunction
  task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s lane%0d got %h expected %h", tag, sel, got, exp);
    end
  endtask
  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("idle", o, IDLE_OUT);
    end
  endtask
  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    pl_en = 1'b1;
    pl_idx = a[10:2];
    pl_val = v;
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[sel][a[10:2]] = v;
  endtask
  task automatic store(input logic [31:0] a, input logic [1:0] ty, input logic [31:0] d, input bit hold);
    int lat, n, w;
    logic [31:0] wa, r, m, mask, sh;
    logic [69:0] e;
    bit bad;
    string tag;
    lat = sel ? 3 : 1;
    req_valid = 1'b1;
    req_addr = a;
    req_type = ty;
    req_wdata = d;
    w = 0;
    while (!o[69] && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", 70'(w), 70'd0);
    if (w >= 20) begin
      req_valid = 1'b0;
      return;
    end
    wa = {a[31:2], 2'b00};
    bad = ty == 2'b01 && a[0];
    r = ref_mem[sel][a[10:2]];
    sh = ty == 2'b00 ? 32'(8 * a[1:0]) : 32'(16 * a[1]);
    mask = (ty == 2'b00 ? 32'hFF : 32'hFFFF) << sh;
    m = ty[1] ? d : (r & ~mask) | ((d << sh) & mask);
    n = (bad || ty[1]) ? 1 : 2 + lat;
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      if (k == n + 1) begin e = IDLE_OUT; tag = "back_idle"; end
      else if (k == n && bad) begin e = {6'b010011, 64'd0}; tag = "err"; end
      else if (k == n) begin e = {6'b011110, wa, m}; tag = "write"; end
      else if (k == 1) begin e = {6'b011000, wa, 32'd0}; tag = "read"; end
      else begin e = {6'b010000, 64'd0}; tag = "wait"; end
      chk(tag, o, e);
      if (k == 1) begin
        req_valid = hold;
        req_addr = $urandom;
        req_type = 2'($urandom);
        req_wdata = $urandom;
      end
    end
    if (!bad) ref_mem[sel][a[10:2]] = m;
    chk("ram_word", 70'(ram_at(a)), 70'(ref_mem[sel][a[10:2]]));
  endtask
  task automatic reset_mid(input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_addr = a;
    req_type = 2'b00;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_read", o, {6'b011000, a[31:2], 2'b00, 32'd0});
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("rst_async", o, IDLE_OUT);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    chk("rst_no_write", 70'(ram_at(a)), 70'(ref_mem[sel][a[10:2]]));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    bit hold;
    for (int l = 0; l < 2; l++) for (int i = 0; i < 512; i++) ref_mem[l][i] = seed(i);
    @(negedge clk);
    chk("reset_state", o, IDLE_OUT);
    @(negedge clk);
    init = 1'b0;
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      idle(2);
      poke(32'h100, 32'h1122_3344);
      store(32'h103, 2'b00, 32'h0000_00AB, 1'b0);
      chk("tp_byte", 70'(ram_at(32'h100)), 70'h0AB22_3344);
      poke(32'h200, 32'hCAFE_1234);
      store(32'h202, 2'b01, 32'h0000_BEEF, 1'b0);
      chk("tp_half_hi", 70'(ram_at(32'h200)), 70'hBEEF_1234);
      poke(32'h200, 32'hCAFE_1234);
      store(32'h200, 2'b01, 32'h0000_BEEF, 1'b0);
      chk("tp_half_lo", 70'(ram_at(32'h200)), 70'hCAFE_BEEF);
      store(32'h304, 2'b11, 32'hDEAD_BEEF, 1'b0);
      chk("tp_word", 70'(ram_at(32'h304)), 70'hDEAD_BEEF);
      poke(32'h400, 32'h0102_0304);
      store(32'h401, 2'b01, 32'h0000_5555, 1'b0);
      chk("tp_misaligned", 70'(ram_at(32'h400)), 70'h0102_0304);
      poke(32'h500, 32'hFFFF_FFFF);
      store(32'h500, 2'b00, 32'h0000_007F, 1'b1);
      store(32'h504, 2'b10, 32'h1234_5678, 1'b0);
      chk("tp_b2b_byte", 70'(ram_at(32'h500)), 70'hFFFF_FF7F);
      poke(32'h600, 32'h0BAD_F00D);
      reset_mid(32'h601, 32'h0000_0099);
      store(32'h601, 2'b00, 32'h0000_0099, 1'b0);
      chk("tp_after_rst", 70'(ram_at(32'h600)), 70'h0BAD_990D);
      for (int i = 0; i < 40; i++) begin
        hold = $urandom_range(0, 1) == 1 && i < 39;
        store($urandom_range(0, 32'h7FF), 2'($urandom), $urandom, hold);
        if (!hold) idle($urandom_range(0, 2));
      end
      idle(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
